// File: rtl/uart_rx_pkg.sv
// Shared UART frame constants and receiver state encoding.
package uart_rx_pkg;

    localparam int unsigned DataBits = 8;
    localparam int unsigned StopBits = 1;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitHigh
    } rx_state_e;

    // Clocks occupied by one complete frame (start + data + stop).
    function automatic int unsigned frame_clks(input int unsigned clks_per_bit);
        return (1 + DataBits + StopBits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Pad-side serial input and SIO register-side receive signals of the UART receiver.
interface uart_rx_if;
    logic       serial_in;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_irq;
    logic       overrun;
    logic       framing_error;

    modport master (
        output serial_in,
        output rx_read,
        input  rx_data,
        input  rx_valid,
        input  rx_irq,
        input  overrun,
        input  framing_error
    );

    modport slave (
        input  serial_in,
        input  rx_read,
        output rx_data,
        output rx_valid,
        output rx_irq,
        output overrun,
        output framing_error
    );
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs, with a configurable reset value.
module uart_rx_sync2 #(
    parameter logic ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver: mid-bit sampling, byte holding register,
// one-cycle receive interrupt and sticky overrun / framing-error flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned ClksPerBit = 16
) (
    input logic      clk_i,
    input logic      rst_i,
    uart_rx_if.slave rx_if
);

    localparam int unsigned CntW = $clog2(ClksPerBit);
    localparam int unsigned BitW = $clog2(DataBits);
    localparam logic [CntW-1:0] HalfM1 = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(ClksPerBit - 1);
    localparam logic [BitW-1:0] LastBit = BitW'(DataBits - 1);

    logic rxs;

    rx_state_e             state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [DataBits-1:0]   shift_q, shift_d;
    logic [DataBits-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  irq_q, irq_d;
    logic                  ovr_q, ovr_d;
    logic                  fe_q, fe_d;

    uart_rx_sync2 #(
        .ResetVal(1'b1)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (rx_if.serial_in),
        .q_o  (rxs)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            irq_q   <= irq_d;
            ovr_q   <= ovr_d;
            fe_q    <= fe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        irq_d   = 1'b0;
        ovr_d   = ovr_q;
        fe_d    = fe_q;

        // A register read clears the flags; completion/error below override it.
        if (rx_if.rx_read) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            fe_d    = 1'b0;
        end

        unique case (state_q)
            RxIdle: begin
                if (!rxs) begin
                    cnt_d   = HalfM1;
                    state_d = RxStart;
                end
            end
            RxStart: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!rxs) begin
                    cnt_d   = FullM1;
                    bit_d   = '0;
                    state_d = RxData;
                end else begin
                    state_d = RxIdle;
                end
            end
            RxData: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Shifting in at the MSB leaves the first bit received in bit 0.
                    shift_d = {rxs, shift_q[DataBits-1:1]};
                    cnt_d   = FullM1;
                    if (bit_q == LastBit) begin
                        state_d = RxStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            RxStop: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    irq_d   = 1'b1;
                    if (valid_q && !rx_if.rx_read) begin
                        ovr_d = 1'b1;
                    end
                    state_d = RxIdle;
                end else begin
                    fe_d    = 1'b1;
                    state_d = RxWaitHigh;
                end
            end
            RxWaitHigh: begin
                // Hold off until the line idles so a break is not seen as a start bit.
                if (rxs) begin
                    state_d = RxIdle;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign rx_if.rx_data       = data_q;
    assign rx_if.rx_valid      = valid_q;
    assign rx_if.rx_irq        = irq_q;
    assign rx_if.overrun       = ovr_q;
    assign rx_if.framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx with an abstract frame-level reference model.
module tb_uart_rx;

    localparam int N = 16;
    localparam int H = N / 2;
    localparam int DoneOfs = 2 + H + 9 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if rx_bus ();

    uart_rx #(
        .ClksPerBit(N)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rx_if(rx_bus)
    );

    int checks = 0;
    int errors = 0;

    int         edge_cnt = 0;
    int         irq_cnt = 0;
    int         irq_edge = -1;
    logic [7:0] irq_data;
    logic       irq_valid;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (rx_bus.rx_irq === 1'b1) begin
            irq_cnt   <= irq_cnt + 1;
            irq_edge  <= edge_cnt;
            irq_data  <= rx_bus.rx_data;
            irq_valid <= rx_bus.rx_valid;
        end
    end

    // Reference model state.
    logic [7:0] exp_data;
    bit         exp_valid;
    bit         exp_ovr;
    bit         exp_fe;
    int         exp_irqs;
    int         t0;

    function automatic void model_reset();
        exp_data  = 8'h00;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_fe    = 1'b0;
    endfunction

    function automatic void model_read();
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_fe    = 1'b0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit stop, input bit rd);
        bit ovr_set;
        ovr_set = stop && exp_valid && !rd;
        if (rd) model_read();
        if (stop) begin
            exp_data  = b;
            exp_valid = 1'b1;
            exp_irqs  = exp_irqs + 1;
            if (ovr_set) exp_ovr = 1'b1;
        end else begin
            exp_fe = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".rx_data"}, 32'(rx_bus.rx_data), 32'(exp_data));
        chk({tag, ".rx_valid"}, 32'(rx_bus.rx_valid), 32'(exp_valid));
        chk({tag, ".overrun"}, 32'(rx_bus.overrun), 32'(exp_ovr));
        chk({tag, ".framing_error"}, 32'(rx_bus.framing_error), 32'(exp_fe));
        chk({tag, ".rx_irq"}, 32'(rx_bus.rx_irq), 32'd0);
        chk({tag, ".irq_count"}, 32'(irq_cnt), 32'(exp_irqs));
    endtask

    task automatic check_irq(input string tag, input logic [7:0] b);
        chk({tag, ".irq_edge"}, 32'(irq_edge), 32'(t0 + DoneOfs));
        chk({tag, ".irq_data"}, 32'(irq_data), 32'(b));
        chk({tag, ".irq_valid"}, 32'(irq_valid), 32'd1);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_bus.serial_in = 1'b1;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_read();
        rx_bus.rx_read = 1'b1;
        cyc();
        rx_bus.rx_read = 1'b0;
        model_read();
    endtask

    // Drives a frame for max_cycles clocks; slots past the stop bit repeat the stop level.
    // rx_read is pulsed on edge t0+read_at when read_at >= 0.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int read_at,
                               input int max_cycles);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        t0 = edge_cnt + 1;
        for (int c = 0; c < max_cycles; c++) begin
            rx_bus.serial_in = (c / N < 10) ? frame[c / N] : stop;
            rx_bus.rx_read   = (read_at >= 0) && (c == read_at);
            cyc();
        end
        rx_bus.serial_in = 1'b1;
        rx_bus.rx_read   = 1'b0;
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b, input int read_at);
        drive_frame(b, 1'b1, read_at, 10 * N);
        model_frame(b, 1'b1, read_at == DoneOfs);
        check_irq(tag, b);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rstop;
        exp_irqs = 0;
        model_reset();
        rx_bus.serial_in = 1'b1;
        rx_bus.rx_read   = 1'b0;

        // Reset values.
        idle(3);
        check_state("reset");
        rst = 1'b0;
        idle(4);

        // Good frame, then read clears rx_valid.
        good_frame("good_a5", 8'hA5, -1);
        do_read();
        check_state("read_a5");

        // Short low glitch on an idle line is ignored.
        rx_bus.serial_in = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        idle(24);
        check_state("glitch");
        good_frame("after_glitch_3c", 8'h3C, -1);
        do_read();

        // Stop bit low with the line held low afterwards.
        drive_frame(8'h3C, 1'b0, -1, 10 * N + 40);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_state("framing");
        idle(30);
        check_state("framing_wait");
        good_frame("after_break_42", 8'h42, -1);
        do_read();
        check_state("read_fe");

        // Back-to-back frames without a read.
        good_frame("ovr_11", 8'h11, -1);
        good_frame("ovr_22", 8'h22, -1);
        do_read();
        check_state("read_ovr");

        // Read coincides with the second completion.
        good_frame("coin_11", 8'h11, -1);
        good_frame("coin_22", 8'h22, DoneOfs);

        // Randomized frames, gaps, stop bits and reads.
        for (int k = 0; k < 8; k++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 3) != 0);
            if (rstop) begin
                good_frame("rand", rb, -1);
            end else begin
                drive_frame(rb, 1'b0, -1, 10 * N + $urandom_range(0, 20));
                model_frame(rb, 1'b0, 1'b0);
                check_state("rand_fe");
            end
            idle(rstop ? $urandom_range(0, 8) : $urandom_range(4, 12));
            if ($urandom_range(0, 1) != 0) do_read();
        end
        idle(4);

        // Asynchronous reset during data bit 3 of 0xFF, with a byte pending.
        good_frame("pre_rst_77", 8'h77, -1);
        drive_frame(8'hFF, 1'b1, -1, 4 * N + H);
        rst = 1'b1;
        #2;
        model_reset();
        check_state("mid_frame_rst");
        idle(2);
        rst = 1'b0;
        idle(5);
        good_frame("after_rst_5a", 8'h5A, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the Z8 SoC's `serialIn` pin, the receive-side counterpart of the transmitter driving `serialOut`.
- Deserialises 8N1 asynchronous frames, LSB first, into a byte holding register.
- Flags completion for the SIO read path and raises a one-cycle receive-interrupt request (IRQ3).
- Sits between the pad and the SIO special-function-register logic.

## Interface
- `CLKS_PER_BIT`, 16, clocks per serial bit; must be even and ≥ 4.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `serialIn`  in  1  raw asynchronous line; idle high.
- `rxRead`  in  1  one-cycle strobe: SIO register read consumed `rxData`.
- `rxData`  out  8  last correctly framed byte.
- `rxValid`  out  1  `rxData` holds an unread byte.
- `rxIrq`  out  1  one-cycle pulse per correctly received byte.
- `overrun`  out  1  sticky; a byte completed while `rxValid` was set.
- `framingError`  out  1  sticky; stop bit sampled low.

## Operation
- **Input synchronisation:** `serialIn` passes through a 2-flop synchroniser; the FSM sees only the synced signal `rxs`.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter (0..7) and a clock counter of width $clog2(CLKS_PER_BIT) are used.
- **IDLE:** when `rxs`=0, load the clock counter for H = CLKS_PER_BIT/2 and go to START.
- **START:** at mid-bit, sample `rxs`.
  - If 0, go to DATA with bit counter 0.
  - If 1 (glitch), return to IDLE with no flags changed.
- **DATA:** every CLKS_PER_BIT clocks, shift `rxs` into the shift register MSB so the result is LSB-first. After bit 7, go to STOP.
- **STOP:** after CLKS_PER_BIT clocks, sample `rxs`.
  - If 1: `rxData` ← shift register, `rxValid` ← 1, `rxIrq` pulses, `overrun` ← 1 if `rxValid` was already 1 and `rxRead` is not asserted in that cycle. Go to IDLE.
  - If 0: `framingError` ← 1; `rxData`, `rxValid` and `rxIrq` are unchanged. Go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs`=1, then go to IDLE. This prevents a break condition from being taken as a new start bit.
- **`rxRead` handling:** clears `rxValid`, `overrun` and `framingError`.
  - If it coincides with a byte completion, completion wins: `rxValid` stays 1 and `overrun` is not set.
  - Same-cycle sticky-flag set and clear: set wins.
- **Reset mid-frame:** aborts the frame. The FSM goes to IDLE and all outputs go to 0. The synchroniser flops reset to 1 (idle line).

## Timing
- **Reset values:** `rxData`=0x00; `rxValid`, `rxIrq`, `overrun`, `framingError` = 0. Synchroniser flops = 1.
- **Edge numbering:** t0 is the first rising edge at which synchroniser stage 1 captures `serialIn`=0. `rxs` is 0 after edge t0+1, and IDLE leaves at edge t0+2. With N=CLKS_PER_BIT and H=N/2:
  - Start-bit check at edge t0+2+H.
  - Data bit i (0..7) sampled at edge t0+2+H+(i+1)·N.
  - Stop bit sampled at edge t0+2+H+9N. `rxValid` and `rxIrq` are high after this edge; `rxIrq` drops one edge later.
  - With N=16: byte available after edge t0+154.
- **Back-to-back frames:** the FSM is back in IDLE H clocks before the nominal end of the stop bit, so frames with no idle gap are accepted.
- **Output registers:** all outputs come directly from flops; no combinational path from `serialIn` or `rxRead` to any output.

## Structure
- **Shared include:** add `uart.vh` alongside `sfr.vh`. It holds the state encodings (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH) and the frame constants (8 data bits, 1 stop bit), shared with the transmitter.
- **Sub-module `sync2`:** one natural sub-module, a 2-flop synchroniser with an async-reset value parameter. It is reused for any other pad input.
- **RTL size:** the FSM, counters and flags live in `uart_rx`, about 150–200 lines.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **Reset:** assert `reset` asynchronously between edges → all outputs 0 immediately, `rxData`=0x00.
- **Good frame:** drive 0xA5 as an 8N1 frame → `rxData`=0xA5 and `rxValid`=1 after edge t0+154; `rxIrq` high for exactly one cycle; `rxRead` → `rxValid`=0.
- **Glitch:** low pulse of 4 clocks on an idle line → no `rxIrq`, `rxValid` stays 0, FSM back in IDLE; a following 0x3C frame is received correctly.
- **Framing error:** 0x3C with stop bit low, line held low for 40 more clocks → `framingError`=1, `rxValid`=0, `rxData` unchanged. No start is detected until the line returns high; the next 0x42 frame is received.
- **Overrun:** frames 0x11 then 0x22 back-to-back, no `rxRead` → `rxData`=0x22, `overrun`=1. `rxRead` clears `rxValid` and `overrun`. Repeat with `rxRead` on the completion edge → `overrun` stays 0.
- **Reset mid-frame:** assert `reset` during data bit 3 of 0xFF → all outputs 0. After release, frame 0x5A gives `rxData`=0x5A and one `rxIrq`.
